// File: rtl/mac_accumulator.sv
// Dot-product accumulator that feeds an external 8x8 array multiplier and sums N_TERMS products per frame.
// Optional macro SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module mac_accumulator #(
    parameter int ACC_W   = 19,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             ovf
);

    // state    | meaning
    // ST_ACC   | accepting operand pairs for the current frame
    // ST_DRAIN | all pairs taken, waiting for in-flight products to be summed
    // ST_DONE  | result presented, waiting for consumer handshake
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(N_TERMS) + 1;
    localparam int SUM_W = ACC_W + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_v1;
    logic             r_v2;
    logic [15:0]      r_prod;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_mul_a;
    logic [7:0]       r_mul_b;

    logic             w_accept;
    logic             w_last;
    logic             w_handshake;
    logic [SUM_W-1:0] w_sum;

    assign in_ready    = (r_state == ST_ACC);
    assign w_accept    = in_valid & in_ready;
    assign w_last      = (r_count == CNT_W'(N_TERMS - 1));
    assign w_handshake = (r_state == ST_DONE) & out_ready;
    // Extra top bit catches the carry out of the accumulator.
    assign w_sum       = {1'b0, r_acc} + SUM_W'(r_prod);

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_valid = (r_state == ST_DONE);
    assign out_acc   = r_acc;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_accept && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_v1 && !r_v2) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else begin
            r_v1   <= w_accept;
            r_v2   <= r_v1;
            r_prod <= mul_p;
            if (w_accept) begin
                r_mul_a <= in_a;
                r_mul_b <= in_b;
            end
            if (w_handshake) begin
                r_count <= '0;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_count <= r_count + 1'b1;
                end
                if (r_v2) begin
                    if (w_sum[ACC_W]) begin
                        r_ovf <= 1'b1;
                    end
`ifdef SATURATE_EN
                    // Once clamped, the accumulator stays at full scale until the frame ends.
                    if (w_sum[ACC_W] || r_ovf) begin
                        r_acc <= '1;
                    end else begin
                        r_acc <= w_sum[ACC_W-1:0];
                    end
`else
                    r_acc <= w_sum[ACC_W-1:0];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: default 19-bit/8-term instance plus a 16-bit/2-term instance for overflow.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [7:0]  in_a, in_b, mul_a, mul_b;
    logic [15:0] mul_p;
    logic [18:0] out_acc;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf;
    logic [7:0]  s_in_a, s_in_b, s_mul_a, s_mul_b;
    logic [15:0] s_mul_p;
    logic [15:0] s_out_acc;

    // Behavioural array multipliers
    assign mul_p   = {8'd0, mul_a} * {8'd0, mul_b};
    assign s_mul_p = {8'd0, s_mul_a} * {8'd0, s_mul_b};

    mac_accumulator #(.ACC_W(19), .N_TERMS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .ovf(ovf)
    );

    mac_accumulator #(.ACC_W(16), .N_TERMS(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_acc(s_out_acc), .ovf(s_ovf)
    );

    int checks = 0;
    int errors = 0;
    int fa [8];
    int fb [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: plain sum of products, then wrap or clamp at 2^w.
    function automatic void model(input int n, input int w, output longint ea, output bit eo);
        longint tot = 0;
        longint lim = longint'(1) << w;
        for (int i = 0; i < n; i++) tot += longint'(fa[i]) * longint'(fb[i]);
        eo = (tot >= lim);
`ifdef SATURATE_EN
        ea = eo ? lim - 1 : tot;
`else
        ea = tot % lim;
`endif
    endfunction

    task automatic send_frame(input int gap_mode, input int n);
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 && i > 0) begin
                in_valid = 1'b0;
                tick;
            end
            if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick;
                end
            end
            in_valid = 1'b1;
            in_a = fa[i][7:0];
            in_b = fb[i][7:0];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_accepting term %0d: got %b want 1", i, in_ready);
            end
            tick;
            checks++;
            if (mul_a !== fa[i][7:0] || mul_b !== fb[i][7:0]) begin
                errors++;
                $display("FAIL mul_operands term %0d: got %0d,%0d want %0d,%0d", i, mul_a, mul_b, fa[i], fb[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input int hold);
        longint ea;
        bit     eo;
        int     lat = 0;
        model(8, 19, ea, eo);
        while (out_valid !== 1'b1 && lat < 20) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s in_ready_drain: got %b want 0", name, in_ready);
            end
            tick;
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s latency: got %0d want 3 cycles", name, lat);
        end
        checks++;
        if (out_acc !== ea[18:0] || ovf !== eo) begin
            errors++;
            $display("FAIL %s result: got acc=%0d ovf=%b want acc=%0d ovf=%b", name, out_acc, ovf, ea, eo);
        end
        repeat (hold) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_acc !== ea[18:0] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall: got v=%b acc=%0d rdy=%b want v=1 acc=%0d rdy=0", name, out_valid, out_acc, in_ready, ea);
            end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 19'd0) begin
            errors++;
            $display("FAIL %s after_handshake: got v=%b rdy=%b acc=%0d want v=0 rdy=1 acc=0", name, out_valid, in_ready, out_acc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 19'd0 || ovf !== 1'b0 ||
            mul_a !== 8'd0 || mul_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b acc=%0d ovf=%b a=%0d b=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, out_acc, ovf, mul_a, mul_b);
        end
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_acc !== 16'd0 || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_small: got rdy=%b v=%b acc=%0d ovf=%b want 1 0 0 0", s_in_ready, s_out_valid, s_out_acc, s_ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin fa[i] = 255; fb[i] = 255; end
        send_frame(0, 8);
        get_result("max_b2b", 0);
    endtask

    task automatic test_gaps;
        for (int i = 0; i < 8; i++) begin fa[i] = i + 1; fb[i] = 2; end
        send_frame(1, 8);
        get_result("gaps", 0);
    endtask

    task automatic test_stall;
        for (int i = 0; i < 8; i++) begin fa[i] = $urandom_range(0, 255); fb[i] = $urandom_range(0, 255); end
        send_frame(0, 8);
        get_result("stall", 5);
        for (int i = 0; i < 8; i++) begin fa[i] = 1; fb[i] = 1; end
        send_frame(0, 8);
        get_result("after_stall", 0);
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 3; i++) begin fa[i] = 10; fb[i] = 10; end
        send_frame(0, 3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_acc !== 19'd0 || mul_a !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got rdy=%b acc=%0d a=%0d v=%b want 1 0 0 0", in_ready, out_acc, mul_a, out_valid);
        end
        for (int i = 0; i < 8; i++) begin fa[i] = 1; fb[i] = 3; end
        send_frame(0, 8);
        get_result("mid_reset", 0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) begin fa[i] = $urandom_range(0, 255); fb[i] = $urandom_range(0, 255); end
            send_frame(2, 8);
            get_result("random", $urandom_range(0, 3));
        end
    endtask

    task automatic small_frame(input string name);
        longint ea;
        bit     eo;
        int     lat = 0;
        model(2, 16, ea, eo);
        for (int i = 0; i < 2; i++) begin
            s_in_valid = 1'b1;
            s_in_a = fa[i][7:0];
            s_in_b = fb[i][7:0];
            tick;
        end
        s_in_valid = 1'b0;
        while (s_out_valid !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        checks++;
        if (lat != 3 || s_out_acc !== ea[15:0] || s_ovf !== eo) begin
            errors++;
            $display("FAIL %s: got lat=%0d acc=%0d ovf=%b want lat=3 acc=%0d ovf=%b", name, lat, s_out_acc, s_ovf, ea, eo);
        end
        s_out_ready = 1'b1;
        tick;
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_ovf !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s clear: got v=%b ovf=%b rdy=%b want 0 0 1", name, s_out_valid, s_ovf, s_in_ready);
        end
    endtask

    task automatic test_overflow;
        fa[0] = 255; fb[0] = 255; fa[1] = 255; fb[1] = 255;
        small_frame("ovf_max");
        fa[0] = 3; fb[0] = 4; fa[1] = 5; fb[1] = 6;
        small_frame("ovf_cleared");
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 2; i++) begin fa[i] = $urandom_range(100, 255); fb[i] = $urandom_range(100, 255); end
            small_frame("ovf_random");
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = 8'd0; s_in_b = 8'd0; s_out_ready = 1'b0;
        test_reset;
        test_back_to_back;
        test_gaps;
        test_stall;
        test_mid_reset;
        test_random;
        test_overflow;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
